// File: rtl/bus_memtest_master.sv
// Bus memory self-test master: writes addr^seed over a word range, reads it back and compares.
// Define BUS_MEMTEST_TIMEOUT_EN to abort a test when a read response never arrives.
module bus_memtest_master #(
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_bi,
  input  logic [CNT_WIDTH-1:0] len_bi,
  input  logic [31:0]          seed_bi,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 timeout_o,
  output logic [CNT_WIDTH-1:0] err_cnt_bo,
  output logic [31:0]          err_addr_bo,
  output logic                 bus_req_o,
  output logic                 bus_we_o,
  output logic [31:0]          bus_addr_bo,
  output logic [3:0]           bus_be_bo,
  output logic [31:0]          bus_wdata_bo,
  input  logic                 bus_ack_i,
  input  logic                 bus_resp_i,
  input  logic [31:0]          bus_rdata_bi
);

  // IDLE wait start | WR write pass | RD_REQ issue read | RD_WAIT await resp | FIN report result
  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, FIN} state_t;

  state_t               state_q;
  logic [31:0]          base_q, seed_q, addr_q, wdata_q, err_addr_q;
  logic [CNT_WIDTH-1:0] len_q, idx_q, err_cnt_q;
  logic                 busy_q, done_q, pass_q, timeout_q, req_q, we_q;

  logic [31:0] base_w, addr_next_w, expect_w;
  logic        last_w, err_full_w;

  assign base_w      = base_addr_bi & 32'hFFFF_FFFC;
  assign addr_next_w = addr_q + 32'd4;
  assign expect_w    = addr_q ^ seed_q;
  assign last_w      = (idx_q == len_q - CNT_WIDTH'(1));
  assign err_full_w  = &err_cnt_q;

`ifdef BUS_MEMTEST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      base_q     <= '0;
      seed_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_addr_q <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      err_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
`ifdef BUS_MEMTEST_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          base_q     <= base_w;
          len_q      <= len_bi;
          seed_q     <= seed_bi;
          idx_q      <= '0;
          addr_q     <= base_w;
          err_cnt_q  <= '0;
          err_addr_q <= '0;
          pass_q     <= 1'b0;
          timeout_q  <= 1'b0;
          busy_q     <= 1'b1;
          if (len_bi == '0) begin
            state_q <= FIN;
          end else begin
            state_q <= WR;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            wdata_q <= base_w ^ seed_bi;
          end
        end
        WR: if (bus_ack_i) begin
          if (last_w) begin
            idx_q   <= '0;
            addr_q  <= base_q;
            we_q    <= 1'b0;
            wdata_q <= '0;
            state_q <= RD_REQ;
          end else begin
            idx_q   <= idx_q + CNT_WIDTH'(1);
            addr_q  <= addr_next_w;
            wdata_q <= addr_next_w ^ seed_q;
          end
        end
        RD_REQ: if (bus_ack_i) begin
          req_q   <= 1'b0;
          state_q <= RD_WAIT;
`ifdef BUS_MEMTEST_TIMEOUT_EN
          tmo_q   <= TW'(TIMEOUT_CYCLES - 1);
`endif
        end
        RD_WAIT: begin
          if (bus_resp_i) begin
            if (bus_rdata_bi != expect_w) begin
              if (!err_full_w) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
              if (err_cnt_q == '0) err_addr_q <= addr_q;
            end
            if (last_w) begin
              state_q <= FIN;
            end else begin
              idx_q   <= idx_q + CNT_WIDTH'(1);
              addr_q  <= addr_next_w;
              req_q   <= 1'b1;
              state_q <= RD_REQ;
            end
          end
`ifdef BUS_MEMTEST_TIMEOUT_EN
          else if (tmo_q == '0) begin
            if (!err_full_w) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
            if (err_cnt_q == '0) err_addr_q <= addr_q;
            timeout_q <= 1'b1;
            state_q   <= FIN;
          end else begin
            tmo_q <= tmo_q - TW'(1);
          end
`endif
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          pass_q  <= (err_cnt_q == '0) && !timeout_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign timeout_o    = timeout_q;
  assign err_cnt_bo   = err_cnt_q;
  assign err_addr_bo  = err_addr_q;
  assign bus_req_o    = req_q;
  assign bus_we_o     = we_q;
  assign bus_addr_bo  = addr_q;
  assign bus_be_bo    = req_q ? 4'hF : 4'h0;
  assign bus_wdata_bo = wdata_q;

endmodule

// File: tb/tb_bus_memtest_master.sv
// Randomized scoreboard bench for bus_memtest_master with a memory-backed bus responder.
module tb_bus_memtest_master;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] base = '0, seed = '0;
  logic [15:0] len = '0;
  logic        busy, done, pass, tmo, req, we;
  logic [15:0] err_cnt;
  logic [31:0] err_addr, addr, wdata;
  logic [3:0]  be;
  logic        ack = 1'b0, resp = 1'b0;
  logic [31:0] rdata = '0;

  always #5 clk = ~clk;

  bus_memtest_master dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_bi(base), .len_bi(len),
    .seed_bi(seed), .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tmo),
    .err_cnt_bo(err_cnt), .err_addr_bo(err_addr), .bus_req_o(req), .bus_we_o(we),
    .bus_addr_bo(addr), .bus_be_bo(be), .bus_wdata_bo(wdata), .bus_ack_i(ack),
    .bus_resp_i(resp), .bus_rdata_bi(rdata)
  );

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} txn_t;
  typedef struct packed {logic pass; logic tmo; logic [15:0] cnt; logic [31:0] eaddr;} res_t;

  txn_t        exp_txn_q[$];
  res_t        exp_res_q[$];
  int          errors = 0, checks = 0;
  int          stall = 0;
  bit          resp_en = 1'b1;
  logic [31:0] mem [logic [31:0]];
  bit          corrupt [logic [31:0]];
  int          wcnt = 0, done_cnt = 0, rd_ack_cnt = 0;
  bit          rd_pend = 1'b0;
  logic [31:0] rd_addr = '0;
  txn_t        held = '0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Responder + monitor: decides ack/resp at negedge, compares against the scoreboard queues.
  always @(negedge clk) begin
    txn_t e;
    res_t r;
    resp = 1'b0;
    if (rst) begin
      rd_pend = 1'b0;
      ack = 1'b0;
      wcnt = 0;
    end else begin
      if (rd_pend) begin
        rd_pend = 1'b0;
        if (resp_en) begin
          resp = 1'b1;
          rdata = (mem.exists(rd_addr) ? mem[rd_addr] : 32'h0) ^
                  (corrupt.exists(rd_addr) ? 32'h1 : 32'h0);
        end
      end
      if (req) begin
        check("byte_enable", 64'(be), 64'hF);
        if (wcnt > 0) begin
          check("stall_addr", 64'(addr), 64'(held.addr));
          check("stall_wdata", 64'(wdata), 64'(held.wdata));
          check("stall_we", 64'(we), 64'(held.we));
        end else begin
          held.we = we; held.addr = addr; held.wdata = wdata;
        end
        if (wcnt >= stall) begin
          ack = 1'b1;
          wcnt = 0;
          if (exp_txn_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: got addr %0h we %0b expected no request", addr, we);
          end else begin
            e = exp_txn_q.pop_front();
            check("txn_we", 64'(we), 64'(e.we));
            check("txn_addr", 64'(addr), 64'(e.addr));
            check("txn_wdata", 64'(wdata), 64'(e.wdata));
          end
          if (we) mem[addr] = wdata;
          else begin rd_pend = 1'b1; rd_addr = addr; rd_ack_cnt++; end
        end else begin
          ack = 1'b0;
          wcnt++;
        end
      end else begin
        ack = 1'b0;
      end
      if (done) begin
        done_cnt++;
        check("busy_at_done", 64'(busy), 64'h0);
        if (exp_res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done expected none");
        end else begin
          r = exp_res_q.pop_front();
          check("pass", 64'(pass), 64'(r.pass));
          check("timeout", 64'(tmo), 64'(r.tmo));
          check("err_cnt", 64'(err_cnt), 64'(r.cnt));
          if (r.cnt != 0) check("err_addr", 64'(err_addr), 64'(r.eaddr));
        end
      end
    end
  end

  task automatic kick(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s,
                      input bit poke, output int cyc);
    int d0;
    @(posedge clk); #1;
    base = b; len = n; seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d0 = done_cnt;
    cyc = 0;
    while (done_cnt == d0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (poke && cyc == 3 && busy) begin
        base = 32'h1234_5670; len = 16'd9; seed = 32'hFFFF_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
      end
    end
    if (done_cnt == d0) begin
      checks++; errors++;
      $display("FAIL done_wait: got no done after %0d cycles expected done", cyc);
      exp_txn_q.delete();
      exp_res_q.delete();
    end
    check("txn_left", 64'(exp_txn_q.size()), 64'h0);
  endtask

  // Reference model: the full expected bus sequence and result from the pattern rules.
  task automatic run_test(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s,
                          input int st, input int pct, input int cidx, input bit poke,
                          output int cyc);
    logic [31:0] a;
    res_t r;
    stall = st;
    corrupt.delete();
    r = '0;
    for (int i = 0; i < int'(n); i++) begin
      a = (b & 32'hFFFF_FFFC) + 32'(4 * i);
      exp_txn_q.push_back('{we: 1'b1, addr: a, wdata: a ^ s});
    end
    for (int i = 0; i < int'(n); i++) begin
      a = (b & 32'hFFFF_FFFC) + 32'(4 * i);
      exp_txn_q.push_back('{we: 1'b0, addr: a, wdata: 32'h0});
      if (i == cidx || $urandom_range(99) < pct) begin
        corrupt[a] = 1'b1;
        if (r.cnt == 0) r.eaddr = a;
        r.cnt++;
      end
    end
    r.pass = (r.cnt == 0);
    exp_res_q.push_back(r);
    kick(b, n, s, poke, cyc);
  endtask

  initial begin
    int cyc, r0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, pass, tmo, req, we, be, err_cnt, 8'h0},
          64'h0);
    check("reset_addr_data", {addr, wdata | err_addr}, 64'h0);
    rst = 1'b0;

    run_test(32'h8000_0000, 16'd4, 32'hA5A5_A5A5, 0, 0, -1, 1'b0, cyc);
    run_test(32'h8000_0000, 16'd4, 32'hA5A5_A5A5, 0, 0, 2, 1'b0, cyc);
    run_test(32'h8000_0000, 16'd4, 32'hA5A5_A5A5, 3, 0, -1, 1'b0, cyc);
    run_test(32'hFFFF_FFF8, 16'd3, 32'h0F0F_1234, 1, 0, -1, 1'b0, cyc);
    run_test(32'h4000_0003, 16'd0, 32'h1111_1111, 0, 0, -1, 1'b0, cyc);
    check("len0_latency_ok", 64'(cyc <= 2), 64'h1);
    run_test(32'h0000_1000, 16'd5, 32'hDEAD_BEEF, 1, 0, 4, 1'b1, cyc);

    for (int k = 0; k < 20; k++)
      run_test($urandom, 16'($urandom_range(0, 8)), $urandom, $urandom_range(0, 2), 30, -1,
               1'($urandom_range(0, 1)), cyc);

    // Reset while a read is outstanding
    stall = 0;
    corrupt.delete();
    for (int i = 0; i < 4; i++)
      exp_txn_q.push_back('{we: 1'b1, addr: 32'h200 + 32'(4 * i), wdata: (32'h200 + 32'(4 * i)) ^ 32'h55});
    exp_txn_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
    r0 = rd_ack_cnt;
    @(posedge clk); #1;
    base = 32'h200; len = 16'd4; seed = 32'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (rd_ack_cnt == r0 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check("reached_rd_wait", 64'(rd_ack_cnt != r0), 64'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midtest_reset_ctl", {busy, done, pass, tmo, req, we, be, err_cnt, 8'h0}, 64'h0);
    check("midtest_reset_addr", 64'(addr), 64'h0);
    exp_txn_q.delete();
    exp_res_q.delete();
    rst = 1'b0;
    run_test(32'h300, 16'd2, 32'h77, 0, 0, -1, 1'b0, cyc);

`ifdef BUS_MEMTEST_TIMEOUT_EN
    begin
      res_t r;
      resp_en = 1'b0;
      stall = 0;
      corrupt.delete();
      exp_txn_q.push_back('{we: 1'b1, addr: 32'h400, wdata: 32'h400 ^ 32'h9});
      exp_txn_q.push_back('{we: 1'b1, addr: 32'h404, wdata: 32'h404 ^ 32'h9});
      exp_txn_q.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0});
      r.pass = 1'b0; r.tmo = 1'b1; r.cnt = 16'd1; r.eaddr = 32'h400;
      exp_res_q.push_back(r);
      kick(32'h400, 16'd2, 32'h9, 1'b0, cyc);
      check("timeout_latency_ok", 64'(cyc >= 255 && cyc <= 262), 64'h1);
      resp_en = 1'b1;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bus_memtest_master.md
Name: bus_memtest_master

Overview:
- Bus initiator that drives the same req/we/addr/be/wdata/ack/resp/rdata bus that the UDM master drives; it is the master end of the interface that the CSR/test-memory responders serve.
- On a start pulse it writes a deterministic pattern over a word range, then reads the range back and compares.
- Reports pass/fail, error count and first failing address.
- Used for on-board self-test of bus-attached RAMs in place of, or next to, the UART debug master.

Parameters:
CNT_WIDTH, 16, width of word-count and error-count fields
TIMEOUT_CYCLES, 255, max cycles waiting for read response (used only with the optional feature)

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset, synchronous, active-high
start_i  input  1  one-cycle start pulse; ignored while busy_o=1
base_addr_bi  input  32  byte base address; bits [1:0] forced to 0 when latched
len_bi  input  CNT_WIDTH  number of 32-bit words to test
seed_bi  input  32  pattern seed
busy_o  output  1  test in progress
done_o  output  1  one-cycle pulse at test end
pass_o  output  1  1 = last test had zero errors; held until next start
timeout_o  output  1  1 = last test aborted on response timeout
err_cnt_bo  output  CNT_WIDTH  mismatch count, saturating at all-ones
err_addr_bo  output  32  address of first mismatch; valid when err_cnt_bo!=0
bus_req_o  output  1  bus request
bus_we_o  output  1  1 = write, 0 = read
bus_addr_bo  output  32  byte address, word aligned
bus_be_bo  output  4  byte enables; always 4'hF while requesting
bus_wdata_bo  output  32  write data
bus_ack_i  input  1  request accepted when bus_req_o && bus_ack_i
bus_resp_i  input  1  read response valid, one-cycle pulse
bus_rdata_bi  input  32  read data, valid with bus_resp_i

Behaviour:
- Reset: all outputs 0. FSM enters IDLE. Counters and latched inputs are cleared. A reset mid-test aborts immediately: bus_req_o is 0 on the cycle after rst_i.
- States: IDLE, WR, RD_REQ, RD_WAIT, FIN.
- IDLE:
  - start_i latches base (with [1:0]=0), len and seed; clears err_cnt, err_addr, pass_o and timeout_o; sets busy_o.
  - If len=0, go to FIN; otherwise go to WR with index i=0.
- Pattern: addr(i) = base + 4*i, mod 2^32 (wraps past 32'hFFFFFFFC to 0). data(i) = addr(i) ^ seed.
- WR:
  - Drives bus_req_o=1, we=1, addr(i), data(i), be=4'hF. Outputs stay stable until the ack cycle.
  - On req&&ack: if i=len-1, set i=0 and go to RD_REQ; otherwise i++ and drive the next word in the following cycle (back-to-back writes allowed; ack in the same cycle req first rises is legal).
- RD_REQ:
  - Drives req=1, we=0, addr(i), wdata=0.
  - On ack, go to RD_WAIT; bus_req_o is 0 on the next cycle.
  - Only one read is outstanding at a time.
- RD_WAIT:
  - req=0. On bus_resp_i, compare bus_rdata_bi with data(i).
  - On mismatch: err_cnt++ (saturating). If this is the first error, err_addr=addr(i).
  - Then, if i=len-1, go to FIN; otherwise i++ and go to RD_REQ.
  - Minimum read-to-read turnaround is ack, then resp (≥1 cycle later), then the next req.
- bus_resp_i outside RD_WAIT is ignored. A resp in the same cycle as the read ack is not accepted; the responder must return resp ≥1 cycle after ack.
- FIN: one cycle. done_o=1, busy_o=0 on the following cycle, pass_o=(err_cnt==0)&&!timeout. Return to IDLE.
- start_i while busy_o=1 has no effect.

Optional Feature:
- Macro BUS_MEMTEST_TIMEOUT_EN defined:
  - A cycle counter runs in RD_WAIT and is cleared on entry.
  - If TIMEOUT_CYCLES cycles pass without bus_resp_i: err_cnt++, err_addr is set if this is the first error, timeout_o=1, and the FSM aborts to FIN (pass_o=0).
- Macro undefined: RD_WAIT waits indefinitely, the counter is not built, and timeout_o is tied 0.

Test Plan:
- Write phase: base=32'h80000000, len=4, seed=32'hA5A5A5A5, responder always-ack with 1-cycle read latency, no errors -> 4 writes at 80000000..8000000C with data 25A5A5A5, 25A5A5A1, 25A5A5AD, 25A5A5A9; 4 reads follow; done_o pulses; pass_o=1; err_cnt_bo=0.
- Corrupted read: same setup, responder returns data ^ 1 for address 80000008 -> err_cnt_bo=1, err_addr_bo=32'h80000008, pass_o=0.
- Stalled bus: responder holds ack low 3 cycles on every request -> bus_addr_bo and bus_wdata_bo stay stable during the stall; no request is duplicated or skipped; pass_o=1.
- Address wrap and zero length: base=32'hFFFFFFF8, len=3 -> addresses FFFFFFF8, FFFFFFFC, 00000000. Then len=0 -> done_o pulses within 2 cycles of start, no bus_req_o, pass_o=1.
- Reset and start while busy: rst_i asserted during RD_WAIT -> next cycle all outputs 0, FSM in IDLE. start_i pulsed while busy -> ignored, test completes normally.
- BUS_MEMTEST_TIMEOUT_EN defined, responder never asserts resp -> after 255 cycles in RD_WAIT: timeout_o=1, err_cnt_bo=1, pass_o=0, done_o pulses.
